deconv_weight_fifo: RTL and testbench
=====================================

// Module: deconv_weight_fifo
// PURPOSE
// - Weight-side responder for the 4-core deconv top. Pulls weight pixels from the weight BRAM reader and
//   buffers one full kernel (SIZE_OF_WEIGHT columns) per core lane.
// - Presents one weight column per lane on weight_fifo_out and services the per-lane rd_en/loop/flush requests.
// - Sits between the weight BRAM reader and the deconv multi-kernel top.
// PARAMETERS
// - PIX_WIDTH       16  bits per weight pixel
// - SIZE_OF_WEIGHT  3   kernel edge; rows per column = columns per kernel
// - N_LANES         4   core lanes; fixed at 4 by the consumer port widths
// PORTS
// - i_clk                    in   1                     clock; single clock domain
// - i_rst_n                  in   1                     reset, asynchronous, active-low
// - weight_reader_en         out  1                     request pixels from the weight BRAM reader
// - weight_reader_valid      in   1                     weight_reader_data_out holds a pixel this cycle
// - weight_reader_data_out   in   PIX_WIDTH             weight pixel
// - weight_fifo_rd_en        in   4                     per-lane advance to the next column
// - weight_fifo_loop         in   4                     per-lane rewind to column 0; data is kept
// - weight_fifo_flush        in   4                     per-lane discard of the kernel
// - weight_fifo_out          out  PIX_WIDTH*SW*4        lane k at [k*SW*PIX_WIDTH +: SW*PIX_WIDTH]; row 0 in the LSBs
// - weight_fifo_export_done  out  1                     all lanes hold a valid column
// - weight_fifo_core_init    out  1                     one-cycle pulse when a kernel set is fully loaded
// - weight_fifo_underrun     out  1                     sticky error; see CONFIGURATION
// BEHAVIOUR
// - Reset values: all outputs 0; all pointers 0; all lanes empty; FSM = FILL.
//   Reset mid-fill discards the partial kernel set.
// - Storage: per lane, an SW x SW pixel array. Fill order is lane-major, then column, then row.
//   Stream pixel i maps to lane i/(SW*SW), col (i/SW)%SW, row i%SW.
// - FSM FILL
//   - weight_reader_en = 1.
//   - Each cycle with weight_reader_valid=1 stores one pixel and increments wr_cnt (0..4*SW*SW-1).
//   - The cycle that stores the last pixel -> INIT.
//   - weight_reader_valid while not in FILL is ignored.
// - FSM INIT (1 cycle)
//   - weight_reader_en = 0; weight_fifo_core_init = 1.
//   - The consumer ORs core_init into rd_en, so this is seen as rd_en=4'hF -> SERVE.
// - FSM SERVE: each lane has rd_ptr in 0..SW and a valid bit.
//   - rd_en[k]: if rd_ptr<SW, out lane k <= col[rd_ptr] and rd_ptr++, registered with 1-cycle latency.
//     If rd_ptr==SW, lane k is exhausted: output is held and valid[k] stays 1.
//   - loop[k]: rd_ptr <= 0. If rd_en[k] is in the same cycle, col 0 is presented and rd_ptr <= 1.
//   - flush[k]: valid[k] <= 0, rd_ptr <= 0, out lane k <= 0. Flush wins over rd_en and loop in the same cycle.
//   - export_done = AND of valid[3:0], registered.
//   - When all 4 lanes are flushed (cumulative, in any cycle order) -> FILL for the next channel; wr_cnt <= 0.
// - Arithmetic: counters are sized with $clog2, unsigned. No wrap: wr_cnt saturates through the FILL->INIT exit.
// - Any rd_en/loop/flush in FILL or INIT is ignored, except the core_init-induced read in INIT.
// CONFIGURATION
// - Macro DECONV_WFIFO_UNDERRUN_DET_EN.
// - Defined: weight_fifo_underrun is set when rd_en[k] arrives with rd_ptr==SW, or in FILL.
//   It is sticky until reset.
// - Not defined: weight_fifo_underrun is tied to 0 and no detection logic is built.
// TESTING
// - Reset, then stream pixels 0x0001..0x0024 with valid=1 continuously:
//   - reader_en drops after the 36th pixel.
//   - core_init pulses 1 cycle later.
//   - Next cycle, lane0 out = {0x0003,0x0002,0x0001}, lane3 = {0x001E,0x001D,0x001C}, export_done=1.
// - With valid toggling 1/0 over the same 36 pixels: same contents, and core_init occurs exactly 1 cycle after the 36th accepted pixel.
// - rd_en=4'b0001 twice: lane0 = {0x0006,0x0005,0x0004} then {0x0009,0x0008,0x0007}; lanes1-3 unchanged.
//   A third rd_en holds lane0, and underrun=1 when the macro is defined.
// - loop[0] and rd_en[0] in the same cycle after exhaustion: lane0 = {0x0003,0x0002,0x0001}, rd_ptr=1.
// - flush=4'hF in one cycle: export_done=0, outputs 0, reader_en=1 next cycle; a second 36-pixel stream reloads correctly.
// - flush[0] and rd_en[0] in the same cycle: lane0 cleared.
//   i_rst_n low mid-FILL (after 10 pixels): a full 36-pixel stream after release gives the scenario-1 result.

Source files
------------

// File: rtl/deconv_weight_fifo_if.sv
// Weight FIFO bundle: BRAM-reader pixel stream in, per-lane column requests in, kernel columns out.
// slave = weight FIFO side, master = reader/consumer side.
interface deconv_weight_fifo_if #(
  parameter int PIX_WIDTH      = 16,
  parameter int SIZE_OF_WEIGHT = 3
);
  logic                                  weight_reader_en;
  logic                                  weight_reader_valid;
  logic [PIX_WIDTH-1:0]                  weight_reader_data_out;
  logic [3:0]                            weight_fifo_rd_en;
  logic [3:0]                            weight_fifo_loop;
  logic [3:0]                            weight_fifo_flush;
  logic [PIX_WIDTH*SIZE_OF_WEIGHT*4-1:0] weight_fifo_out;
  logic                                  weight_fifo_export_done;
  logic                                  weight_fifo_core_init;
  logic                                  weight_fifo_underrun;

  modport slave (
    output weight_reader_en,
    input  weight_reader_valid,
    input  weight_reader_data_out,
    input  weight_fifo_rd_en,
    input  weight_fifo_loop,
    input  weight_fifo_flush,
    output weight_fifo_out,
    output weight_fifo_export_done,
    output weight_fifo_core_init,
    output weight_fifo_underrun
  );

  modport master (
    input  weight_reader_en,
    output weight_reader_valid,
    output weight_reader_data_out,
    output weight_fifo_rd_en,
    output weight_fifo_loop,
    output weight_fifo_flush,
    input  weight_fifo_out,
    input  weight_fifo_export_done,
    input  weight_fifo_core_init,
    input  weight_fifo_underrun
  );
endinterface

// File: rtl/deconv_weight_fifo.sv
// Buffers one SWxSW weight kernel per lane and serves it column by column to each core lane.
// Latency: a column appears 1 cycle after rd_en (or core_init); the reader is pulled only while filling.
// Backpressure: none once serving; lanes hold when exhausted. Define DECONV_WFIFO_UNDERRUN_DET_EN for underrun flag.
module deconv_weight_fifo #(
  parameter int PIX_WIDTH      = 16,
  parameter int SIZE_OF_WEIGHT = 3,
  parameter int N_LANES        = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  deconv_weight_fifo_if.slave  wf
);
  localparam int SW    = SIZE_OF_WEIGHT;
  localparam int COL_W = SW * PIX_WIDTH;
  localparam int KSZ   = SW * SW;
  localparam int TOTAL = N_LANES * KSZ;
  localparam int CNT_W = $clog2(TOTAL);
  localparam int PTR_W = $clog2(SW + 1);

  typedef enum logic [1:0] {FILL, INIT, SERVE} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           wr_cnt;
  logic [PIX_WIDTH-1:0]       mem [TOTAL];
  logic [PTR_W-1:0]           rd_ptr   [N_LANES];
  logic [PTR_W-1:0]           ptr_nxt  [N_LANES];
  logic [PTR_W-1:0]           base_ptr [N_LANES];
  logic [COL_W-1:0]           lane_q   [N_LANES];
  logic [COL_W-1:0]           lane_nxt [N_LANES];
  logic [COL_W-1:0]           col_dat  [N_LANES];
  logic [N_LANES-1:0]         vld_q;
  logic [N_LANES-1:0]         vld_nxt;
  logic [N_LANES-1:0]         rd_hit;
  logic [N_LANES-1:0]         lp_hit;
  logic [N_LANES-1:0]         fl_hit;
  logic [N_LANES-1:0]         flushed;
  logic                       all_flushed;
  logic [CNT_W-1:0]           idx;
  logic                       pix_wr;
  logic                       reader_en_q;
  logic                       core_init_q;
  logic                       export_done_q;
  logic [COL_W*N_LANES-1:0]   out_flat;

  // Stream index equals lane*KSZ + col*SW + row, so wr_cnt addresses storage directly.
  assign pix_wr = (state == FILL) && wf.weight_reader_valid;

  always_ff @(posedge i_clk) begin
    if (pix_wr) begin
      mem[wr_cnt] <= wf.weight_reader_data_out;
    end
  end

  always_comb begin
    idx = '0;
    for (int k = 0; k < N_LANES; k++) begin
      // INIT is the consumer's core_init-induced read of column 0 on every lane.
      rd_hit[k]   = (state == INIT) ||
                    ((state == SERVE) && wf.weight_fifo_rd_en[k] && !flushed[k]);
      lp_hit[k]   = (state == SERVE) && wf.weight_fifo_loop[k] && !flushed[k];
      fl_hit[k]   = (state == SERVE) && wf.weight_fifo_flush[k];
      base_ptr[k] = lp_hit[k] ? '0 : rd_ptr[k];
      col_dat[k]  = '0;
      for (int r = 0; r < SW; r++) begin
        idx = CNT_W'(k * KSZ + r) + CNT_W'(base_ptr[k]) * CNT_W'(SW);
        col_dat[k][r*PIX_WIDTH +: PIX_WIDTH] = mem[idx];
      end

      ptr_nxt[k]  = rd_ptr[k];
      vld_nxt[k]  = vld_q[k];
      lane_nxt[k] = lane_q[k];
      if (fl_hit[k]) begin
        ptr_nxt[k]  = '0;
        vld_nxt[k]  = 1'b0;
        lane_nxt[k] = '0;
      end else if (rd_hit[k] && (base_ptr[k] < PTR_W'(SW))) begin
        lane_nxt[k] = col_dat[k];
        ptr_nxt[k]  = base_ptr[k] + PTR_W'(1);
        vld_nxt[k]  = 1'b1;
      end else if (lp_hit[k]) begin
        ptr_nxt[k]  = '0;
      end
    end
  end

  assign all_flushed = &(flushed | fl_hit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= FILL;
      wr_cnt        <= '0;
      reader_en_q   <= 1'b0;
      core_init_q   <= 1'b0;
      export_done_q <= 1'b0;
      vld_q         <= '0;
      flushed       <= '0;
      for (int k = 0; k < N_LANES; k++) begin
        rd_ptr[k] <= '0;
        lane_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        rd_ptr[k] <= ptr_nxt[k];
        lane_q[k] <= lane_nxt[k];
      end
      vld_q         <= vld_nxt;
      export_done_q <= &vld_nxt;
      case (state)
        FILL: begin
          reader_en_q <= 1'b1;
          core_init_q <= 1'b0;
          if (wf.weight_reader_valid) begin
            // wr_cnt stays on the last index through the exit; it is cleared on re-entry.
            if (wr_cnt == CNT_W'(TOTAL - 1)) begin
              state       <= INIT;
              reader_en_q <= 1'b0;
              core_init_q <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + CNT_W'(1);
            end
          end
        end
        INIT: begin
          core_init_q <= 1'b0;
          flushed     <= '0;
          state       <= SERVE;
        end
        SERVE: begin
          if (all_flushed) begin
            state       <= FILL;
            reader_en_q <= 1'b1;
            wr_cnt      <= '0;
            flushed     <= '0;
          end else begin
            flushed <= flushed | fl_hit;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef DECONV_WFIFO_UNDERRUN_DET_EN
  logic [N_LANES-1:0] ur_hit;
  logic               underrun_q;

  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      ur_hit[k] = ((state == FILL) && wf.weight_fifo_rd_en[k]) ||
                  ((state == SERVE) && wf.weight_fifo_rd_en[k] && !flushed[k] &&
                   !lp_hit[k] && !fl_hit[k] && (rd_ptr[k] == PTR_W'(SW)));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      underrun_q <= 1'b0;
    end else if (|ur_hit) begin
      underrun_q <= 1'b1;
    end
  end

  assign wf.weight_fifo_underrun = underrun_q;
`else
  assign wf.weight_fifo_underrun = 1'b0;
`endif

  always_comb begin
    out_flat = '0;
    for (int k = 0; k < N_LANES; k++) begin
      out_flat[k*COL_W +: COL_W] = lane_q[k];
    end
  end

  assign wf.weight_fifo_out             = out_flat;
  assign wf.weight_reader_en            = reader_en_q;
  assign wf.weight_fifo_core_init       = core_init_q;
  assign wf.weight_fifo_export_done     = export_done_q;
endmodule

// File: tb/tb_deconv_weight_fifo.sv
// Directed bench for deconv_weight_fifo: fill, serve, loop, flush and reset scenarios.
module tb_deconv_weight_fifo;
  localparam int COL = 48;
`ifdef DECONV_WFIFO_UNDERRUN_DET_EN
  localparam logic UR_EXP = 1'b1;
`else
  localparam logic UR_EXP = 1'b0;
`endif

  logic i_clk;
  logic i_rst_n;
  int   n_cmp;
  int   n_err;

  deconv_weight_fifo_if #(.PIX_WIDTH(16), .SIZE_OF_WEIGHT(3)) wf ();

  deconv_weight_fifo #(.PIX_WIDTH(16), .SIZE_OF_WEIGHT(3), .N_LANES(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wf      (wf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [COL-1:0] lane(input int k);
    return wf.weight_fifo_out[k*COL +: COL];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic stream(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      wf.weight_reader_valid    = 1'b1;
      wf.weight_reader_data_out = 16'(i + 1);
      tick();
      if (toggle) begin
        wf.weight_reader_valid = 1'b0;
        tick();
      end
    end
    wf.weight_reader_valid = 1'b0;
  endtask

  task automatic last_pixel();
    wf.weight_reader_valid    = 1'b1;
    wf.weight_reader_data_out = 16'h0024;
    tick();
    wf.weight_reader_valid    = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    wf.weight_reader_valid = 1'b0;
    wf.weight_reader_data_out = '0;
    wf.weight_fifo_rd_en = '0;
    wf.weight_fifo_loop = '0;
    wf.weight_fifo_flush = '0;
    tick();
    tick();
    n_cmp++; if (wf.weight_reader_en !== 1'b0) begin n_err++; $display("FAIL reset_reader_en got %b exp 0", wf.weight_reader_en); end
    n_cmp++; if (wf.weight_fifo_out !== '0) begin n_err++; $display("FAIL reset_out got %h exp 0", wf.weight_fifo_out); end
    n_cmp++; if (wf.weight_fifo_export_done !== 1'b0) begin n_err++; $display("FAIL reset_export_done got %b exp 0", wf.weight_fifo_export_done); end
    n_cmp++; if (wf.weight_fifo_core_init !== 1'b0) begin n_err++; $display("FAIL reset_core_init got %b exp 0", wf.weight_fifo_core_init); end
    n_cmp++; if (wf.weight_fifo_underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b exp 0", wf.weight_fifo_underrun); end
    i_rst_n = 1'b1;
    tick();
    n_cmp++; if (wf.weight_reader_en !== 1'b1) begin n_err++; $display("FAIL fill_reader_en got %b exp 1", wf.weight_reader_en); end
  endtask

  task automatic test_fill_continuous();
    stream(35, 1'b0);
    n_cmp++; if (wf.weight_reader_en !== 1'b1) begin n_err++; $display("FAIL c_reader_en_pre got %b exp 1", wf.weight_reader_en); end
    n_cmp++; if (wf.weight_fifo_core_init !== 1'b0) begin n_err++; $display("FAIL c_core_init_pre got %b exp 0", wf.weight_fifo_core_init); end
    last_pixel();
    n_cmp++; if (wf.weight_reader_en !== 1'b0) begin n_err++; $display("FAIL c_reader_en_drop got %b exp 0", wf.weight_reader_en); end
    n_cmp++; if (wf.weight_fifo_core_init !== 1'b1) begin n_err++; $display("FAIL c_core_init got %b exp 1", wf.weight_fifo_core_init); end
    n_cmp++; if (wf.weight_fifo_export_done !== 1'b0) begin n_err++; $display("FAIL c_export_early got %b exp 0", wf.weight_fifo_export_done); end
    tick();
    n_cmp++; if (wf.weight_fifo_core_init !== 1'b0) begin n_err++; $display("FAIL c_core_init_pulse got %b exp 0", wf.weight_fifo_core_init); end
    n_cmp++; if (lane(0) !== 48'h0003_0002_0001) begin n_err++; $display("FAIL c_lane0 got %h exp 000300020001", lane(0)); end
    n_cmp++; if (lane(1) !== 48'h000C_000B_000A) begin n_err++; $display("FAIL c_lane1 got %h exp 000c000b000a", lane(1)); end
    n_cmp++; if (lane(2) !== 48'h0015_0014_0013) begin n_err++; $display("FAIL c_lane2 got %h exp 001500140013", lane(2)); end
    n_cmp++; if (lane(3) !== 48'h001E_001D_001C) begin n_err++; $display("FAIL c_lane3 got %h exp 001e001d001c", lane(3)); end
    n_cmp++; if (wf.weight_fifo_export_done !== 1'b1) begin n_err++; $display("FAIL c_export_done got %b exp 1", wf.weight_fifo_export_done); end
  endtask

  task automatic test_read_advance();
    wf.weight_fifo_rd_en = 4'b0001;
    tick();
    n_cmp++; if (lane(0) !== 48'h0006_0005_0004) begin n_err++; $display("FAIL rd1_lane0 got %h exp 000600050004", lane(0)); end
    n_cmp++; if (lane(1) !== 48'h000C_000B_000A) begin n_err++; $display("FAIL rd1_lane1 got %h exp 000c000b000a", lane(1)); end
    tick();
    n_cmp++; if (lane(0) !== 48'h0009_0008_0007) begin n_err++; $display("FAIL rd2_lane0 got %h exp 000900080007", lane(0)); end
    n_cmp++; if (lane(3) !== 48'h001E_001D_001C) begin n_err++; $display("FAIL rd2_lane3 got %h exp 001e001d001c", lane(3)); end
    n_cmp++; if (wf.weight_fifo_underrun !== 1'b0) begin n_err++; $display("FAIL rd2_underrun got %b exp 0", wf.weight_fifo_underrun); end
    tick();
    wf.weight_fifo_rd_en = 4'b0000;
    n_cmp++; if (lane(0) !== 48'h0009_0008_0007) begin n_err++; $display("FAIL rd3_hold got %h exp 000900080007", lane(0)); end
    n_cmp++; if (wf.weight_fifo_export_done !== 1'b1) begin n_err++; $display("FAIL rd3_export got %b exp 1", wf.weight_fifo_export_done); end
    n_cmp++; if (wf.weight_fifo_underrun !== UR_EXP) begin n_err++; $display("FAIL rd3_underrun got %b exp %b", wf.weight_fifo_underrun, UR_EXP); end
  endtask

  task automatic test_loop();
    wf.weight_fifo_loop = 4'b0001;
    wf.weight_fifo_rd_en = 4'b0001;
    tick();
    wf.weight_fifo_loop = 4'b0000;
    n_cmp++; if (lane(0) !== 48'h0003_0002_0001) begin n_err++; $display("FAIL loop_rd_lane0 got %h exp 000300020001", lane(0)); end
    tick();
    wf.weight_fifo_rd_en = 4'b0000;
    n_cmp++; if (lane(0) !== 48'h0006_0005_0004) begin n_err++; $display("FAIL loop_ptr1_lane0 got %h exp 000600050004", lane(0)); end
    wf.weight_fifo_loop = 4'b0010;
    tick();
    wf.weight_fifo_loop = 4'b0000;
    n_cmp++; if (lane(1) !== 48'h000C_000B_000A) begin n_err++; $display("FAIL loop_only_lane1 got %h exp 000c000b000a", lane(1)); end
    wf.weight_fifo_rd_en = 4'b0010;
    tick();
    wf.weight_fifo_rd_en = 4'b0000;
    n_cmp++; if (lane(1) !== 48'h000C_000B_000A) begin n_err++; $display("FAIL loop_rewind_lane1 got %h exp 000c000b000a", lane(1)); end
  endtask

  task automatic test_flush_partial();
    wf.weight_fifo_flush = 4'b0001;
    wf.weight_fifo_rd_en = 4'b0001;
    tick();
    wf.weight_fifo_flush = 4'b0000;
    n_cmp++; if (lane(0) !== 48'h0) begin n_err++; $display("FAIL fl0_lane0 got %h exp 0", lane(0)); end
    n_cmp++; if (wf.weight_fifo_export_done !== 1'b0) begin n_err++; $display("FAIL fl0_export got %b exp 0", wf.weight_fifo_export_done); end
    n_cmp++; if (lane(2) !== 48'h0015_0014_0013) begin n_err++; $display("FAIL fl0_lane2 got %h exp 001500140013", lane(2)); end
    tick();
    wf.weight_fifo_rd_en = 4'b0000;
    n_cmp++; if (lane(0) !== 48'h0) begin n_err++; $display("FAIL fl0_rd_ignored got %h exp 0", lane(0)); end
    n_cmp++; if (wf.weight_reader_en !== 1'b0) begin n_err++; $display("FAIL fl0_reader_en got %b exp 0", wf.weight_reader_en); end
    wf.weight_fifo_flush = 4'b1110;
    tick();
    wf.weight_fifo_flush = 4'b0000;
    n_cmp++; if (wf.weight_reader_en !== 1'b1) begin n_err++; $display("FAIL flrest_reader_en got %b exp 1", wf.weight_reader_en); end
    n_cmp++; if (wf.weight_fifo_out !== '0) begin n_err++; $display("FAIL flrest_out got %h exp 0", wf.weight_fifo_out); end
  endtask

  task automatic test_fill_toggle();
    stream(35, 1'b1);
    n_cmp++; if (wf.weight_fifo_core_init !== 1'b0) begin n_err++; $display("FAIL t_core_init_pre got %b exp 0", wf.weight_fifo_core_init); end
    n_cmp++; if (wf.weight_reader_en !== 1'b1) begin n_err++; $display("FAIL t_reader_en_pre got %b exp 1", wf.weight_reader_en); end
    last_pixel();
    n_cmp++; if (wf.weight_fifo_core_init !== 1'b1) begin n_err++; $display("FAIL t_core_init got %b exp 1", wf.weight_fifo_core_init); end
    tick();
    n_cmp++; if (lane(0) !== 48'h0003_0002_0001) begin n_err++; $display("FAIL t_lane0 got %h exp 000300020001", lane(0)); end
    n_cmp++; if (lane(3) !== 48'h001E_001D_001C) begin n_err++; $display("FAIL t_lane3 got %h exp 001e001d001c", lane(3)); end
    n_cmp++; if (wf.weight_fifo_export_done !== 1'b1) begin n_err++; $display("FAIL t_export_done got %b exp 1", wf.weight_fifo_export_done); end
  endtask

  task automatic test_flush_all();
    wf.weight_fifo_flush = 4'hF;
    tick();
    wf.weight_fifo_flush = 4'h0;
    n_cmp++; if (wf.weight_fifo_export_done !== 1'b0) begin n_err++; $display("FAIL fa_export got %b exp 0", wf.weight_fifo_export_done); end
    n_cmp++; if (wf.weight_fifo_out !== '0) begin n_err++; $display("FAIL fa_out got %h exp 0", wf.weight_fifo_out); end
    n_cmp++; if (wf.weight_reader_en !== 1'b1) begin n_err++; $display("FAIL fa_reader_en got %b exp 1", wf.weight_reader_en); end
  endtask

  task automatic test_reset_midfill();
    stream(10, 1'b0);
    i_rst_n = 1'b0;
    #2;
    n_cmp++; if (wf.weight_reader_en !== 1'b0) begin n_err++; $display("FAIL mr_reader_en got %b exp 0", wf.weight_reader_en); end
    n_cmp++; if (wf.weight_fifo_underrun !== 1'b0) begin n_err++; $display("FAIL mr_underrun got %b exp 0", wf.weight_fifo_underrun); end
    tick();
    i_rst_n = 1'b1;
    tick();
    stream(35, 1'b0);
    last_pixel();
    n_cmp++; if (wf.weight_fifo_core_init !== 1'b1) begin n_err++; $display("FAIL mr_core_init got %b exp 1", wf.weight_fifo_core_init); end
    tick();
    n_cmp++; if (lane(0) !== 48'h0003_0002_0001) begin n_err++; $display("FAIL mr_lane0 got %h exp 000300020001", lane(0)); end
    n_cmp++; if (lane(3) !== 48'h001E_001D_001C) begin n_err++; $display("FAIL mr_lane3 got %h exp 001e001d001c", lane(3)); end
    n_cmp++; if (wf.weight_fifo_export_done !== 1'b1) begin n_err++; $display("FAIL mr_export_done got %b exp 1", wf.weight_fifo_export_done); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill_continuous();
    test_read_advance();
    test_loop();
    test_flush_partial();
    test_fill_toggle();
    test_flush_all();
    test_reset_midfill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
